sobel_window_gen: RTL and testbench

Parametrised 3x3 window generator between the grayscale stage and the sobel stage of the edge-detection pipeline. It drains a raster-order grayscale pixel stream from an upstream FIFO and writes one full 3x3 neighbourhood per image pixel, plus a border flag, into a downstream FIFO. Image size and pixel width are generic, and the frame is arbitrary-sized rather than fixed at 720x540. Frames are processed back-to-back, so successive frames need no reset.

---
 rtl/sobel_window_gen.sv | 183 ++++++++++++++++++
 tb/tb_sobel_window_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood generator for the sobel stage: raster pixel stream in, zero-filled windows plus border flag out.
// Optional build macro SOBEL_WIN_STALL_CNT_EN adds a saturating back-pressure cycle counter (stall_count).
module sobel_window_gen #(
  parameter int unsigned IMG_WIDTH    = 720,
  parameter int unsigned IMG_HEIGHT   = 540,
  parameter int unsigned PIXEL_DWIDTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [PIXEL_DWIDTH-1:0]     in_dout,
  input  logic                        in_empty,
  output logic                        in_rd_en,
  output logic [9*PIXEL_DWIDTH:0]     out_din,
  input  logic                        out_full,
  output logic                        out_wr_en,
  output logic                        frame_done
`ifdef SOBEL_WIN_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_count
`endif
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT + 2);
  localparam int unsigned DW = PIXEL_DWIDTH;
  localparam int unsigned OW = 9 * DW + 1;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   in_col, cen_col;
  logic [RW-1:0]   in_row, cen_row;
  logic            valid, out_last, last_loaded;
  logic            advance, shift, load, load_last;
  logic [DW-1:0]   lb0 [IMG_WIDTH];
  logic [DW-1:0]   lb1 [IMG_WIDTH];
  logic [DW-1:0]   lb0_rd, lb1_rd, new_pix;
  logic [DW-1:0]   win    [3][3];
  logic [DW-1:0]   win_sh [3][3];
  logic            top_z, bot_z, left_z, right_z;
  logic [OW-1:0]   out_nxt;

  assign advance    = !valid || !out_full;
  assign out_wr_en  = !reset && valid && !out_full;
  assign frame_done = out_wr_en && out_last;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (in_rd_en && in_row == RW'(1) && in_col == '0) state_d = RUN;
      RUN:     if (in_rd_en && in_row == RW'(IMG_HEIGHT - 1) && in_col == CW'(IMG_WIDTH - 1))
                 state_d = FLUSH;
      FLUSH:   if (frame_done) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Output/strobe logic; FLUSH shifts virtual zero pixels until the last centre is loaded
  always_comb begin
    in_rd_en = 1'b0;
    shift    = 1'b0;
    load     = 1'b0;
    case (state_q)
      FILL: begin
        in_rd_en = !reset && advance && !in_empty;
        shift    = in_rd_en;
      end
      RUN: begin
        in_rd_en = !reset && advance && !in_empty;
        shift    = in_rd_en;
        load     = in_rd_en;
      end
      FLUSH: begin
        shift = !reset && advance && !last_loaded;
        load  = shift;
      end
      default: ;
    endcase
  end

  assign load_last = load && cen_row == RW'(IMG_HEIGHT - 1) && cen_col == CW'(IMG_WIDTH - 1);
  assign new_pix   = (state_q == FLUSH) ? '0 : in_dout;
  assign lb0_rd    = lb0[in_col];
  assign lb1_rd    = lb1[in_col];

  // Next window: shift left one column, new column is {row-2, row-1, current}
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_sh[r][0] = win[r][1];
      win_sh[r][1] = win[r][2];
    end
    win_sh[0][2] = lb0_rd;
    win_sh[1][2] = lb1_rd;
    win_sh[2][2] = new_pix;
  end

  assign top_z   = cen_row == '0;
  assign bot_z   = cen_row == RW'(IMG_HEIGHT - 1);
  assign left_z  = cen_col == '0;
  assign right_z = cen_col == CW'(IMG_WIDTH - 1);

  // Masking hides out-of-image rows/columns, including stale line-buffer data and row-wrap history
  always_comb begin
    out_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!((i == 0 && top_z) || (i == 2 && bot_z) || (j == 0 && left_z) || (j == 2 && right_z)))
          out_nxt[(3*i+j)*DW +: DW] = win_sh[i][j];
      end
    end
    out_nxt[OW-1] = top_z || bot_z || left_z || right_z;
  end

  // Line buffers and shift window carry no reset
  always_ff @(posedge clock) begin
    if (shift) begin
      lb0[in_col] <= lb1_rd;
      lb1[in_col] <= new_pix;
      win         <= win_sh;
    end
  end

  // Counters and output register
  always_ff @(posedge clock) begin
    if (reset) begin
      in_col      <= '0;
      in_row      <= '0;
      cen_col     <= '0;
      cen_row     <= '0;
      last_loaded <= 1'b0;
      valid       <= 1'b0;
      out_last    <= 1'b0;
      out_din     <= '0;
    end else begin
      if (frame_done) begin
        in_col      <= '0;
        in_row      <= '0;
        cen_col     <= '0;
        cen_row     <= '0;
        last_loaded <= 1'b0;
      end else begin
        if (shift) begin
          if (in_col == CW'(IMG_WIDTH - 1)) begin
            in_col <= '0;
            in_row <= in_row + RW'(1);
          end else begin
            in_col <= in_col + CW'(1);
          end
        end
        if (load) begin
          if (cen_col == CW'(IMG_WIDTH - 1)) begin
            cen_col <= '0;
            cen_row <= cen_row + RW'(1);
          end else begin
            cen_col <= cen_col + CW'(1);
          end
        end
        if (load_last) last_loaded <= 1'b1;
      end
      if (advance) begin
        valid    <= load;
        out_last <= load_last;
        if (load) out_din <= out_nxt;
      end
    end
  end

`ifdef SOBEL_WIN_STALL_CNT_EN
  // Saturating count of cycles a window waits on a full downstream FIFO
  always_ff @(posedge clock) begin
    if (reset || frame_done)                     stall_count <= '0;
    else if (valid && out_full && stall_count != '1) stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 4x3 image: expected windows queued at stimulus time, popped on writes.
// Stall-counter checks are active when SOBEL_WIN_STALL_CNT_EN is defined.
module tb_sobel_window_gen;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned D  = 8;
  localparam int unsigned OW = 9 * D + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [D-1:0]  in_dout;
  logic          in_empty;
  logic          in_rd_en;
  logic [OW-1:0] out_din;
  logic          out_full;
  logic          out_wr_en;
  logic          frame_done;
`ifdef SOBEL_WIN_STALL_CNT_EN
  logic [31:0]   stall_count;
`endif

  sobel_window_gen #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .PIXEL_DWIDTH(D)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_dout    (in_dout),
    .in_empty   (in_empty),
    .in_rd_en   (in_rd_en),
    .out_din    (out_din),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .frame_done (frame_done)
`ifdef SOBEL_WIN_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  int            checks = 0;
  int            failures = 0;
  int            accepted = 0;
  int            written = 0;
  int            accepted_at_first = 0;
  bit            starve = 1'b0;
  bit            tog = 1'b0;
  logic [D-1:0]  src[$];
  logic [OW-1:0] sb[$];
  bit            sb_last[$];
  logic [OW-1:0] log_q[$];

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue a frame's pixels and its zero-filled windows in raster order of centre
  task automatic load_frame(input int base);
    logic [D-1:0]  pix [H][W];
    logic [OW-1:0] w;
    int rr, cc;
    for (int r = 0; r < int'(H); r++)
      for (int c = 0; c < int'(W); c++) begin
        pix[r][c] = D'(base + r * int'(W) + c);
        src.push_back(pix[r][c]);
      end
    for (int r = 0; r < int'(H); r++)
      for (int c = 0; c < int'(W); c++) begin
        w = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            rr = r + i - 1;
            cc = c + j - 1;
            if (rr >= 0 && rr < int'(H) && cc >= 0 && cc < int'(W))
              w[(3*i+j)*D +: D] = pix[rr][cc];
          end
        w[OW-1] = (r == 0) || (r == int'(H) - 1) || (c == 0) || (c == int'(W) - 1);
        sb.push_back(w);
        sb_last.push_back((r == int'(H) - 1) && (c == int'(W) - 1));
      end
  endtask

  task automatic drive_inputs();
    in_empty = (src.size() == 0) || (starve && tog);
    in_dout  = (src.size() > 0) ? src[0] : '0;
  endtask

  // One clock: sample strobes at the falling edge, update the source FIFO model after the rising edge
  task automatic cycle();
    logic          rd, wr;
    logic [OW-1:0] exp;
    bit            el;
    @(negedge clock);
    rd = in_rd_en;
    wr = out_wr_en;
    check("rd_while_empty", OW'(rd & in_empty), '0);
    if (out_full) check("rd_while_full", OW'(rd), '0);
    if (wr) begin
      if (sb.size() == 0) begin
        check("extra_write", OW'(wr), '0);
      end else begin
        exp = sb.pop_front();
        el  = sb_last.pop_front();
        check("window", out_din, exp);
        check("frame_done", OW'(frame_done), OW'(el));
        if (written == 0) accepted_at_first = accepted;
        log_q.push_back(out_din);
        written++;
      end
    end else begin
      check("frame_done_idle", OW'(frame_done), '0);
    end
    @(posedge clock);
    #1;
    if (rd) begin
      void'(src.pop_front());
      accepted++;
    end
    tog = ~tog;
    drive_inputs();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    out_full = 1'b0;
    src.delete();
    sb.delete();
    sb_last.delete();
    log_q.delete();
    drive_inputs();
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_din", out_din, '0);
    check("rst_wr_en", OW'(out_wr_en), '0);
    check("rst_rd_en", OW'(in_rd_en), '0);
    check("rst_frame_done", OW'(frame_done), '0);
    reset    = 1'b0;
    accepted = 0;
    written  = 0;
    drive_inputs();
  endtask

  task automatic run_to_end(input int bound, input string tag);
    int n = 0;
    while ((sb.size() > 0 || src.size() > 0) && n < bound) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, OW'(sb.size()), '0);
    repeat (4) cycle();
  endtask

  initial begin
    int n;
    logic [OW-1:0] held;
    reset    = 1'b1;
    out_full = 1'b0;
    in_dout  = '0;
    in_empty = 1'b1;

    // Basic frame
    do_reset();
    load_frame(1);
    drive_inputs();
    run_to_end(200, "t1");
    check("t1_first_lag", OW'(accepted_at_first), OW'(6));
    check("t1_count", OW'(written), OW'(12));
    check("t1_first_win", (log_q.size() > 0) ? log_q[0] : '0,
          {1'b1, 8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0});
    check("t1_c11_win", (log_q.size() > 5) ? log_q[5] : '0,
          {1'b0, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1});

    // Back-pressure mid-RUN
    do_reset();
    load_frame(1);
    drive_inputs();
    n = 0;
    while (written < 3 && n < 100) begin
      cycle();
      n++;
    end
    out_full = 1'b1;
    held = out_din;
    repeat (10) begin
      cycle();
      check("t2_hold", out_din, held);
    end
`ifdef SOBEL_WIN_STALL_CNT_EN
    check("t2_stall_cnt", OW'(stall_count), OW'(10));
`endif
    out_full = 1'b0;
    run_to_end(200, "t2");
    check("t2_count", OW'(written), OW'(12));
`ifdef SOBEL_WIN_STALL_CNT_EN
    check("t2_stall_clr", OW'(stall_count), '0);
`endif

    // Starved input
    do_reset();
    starve = 1'b1;
    load_frame(1);
    drive_inputs();
    run_to_end(400, "t3");
    check("t3_count", OW'(written), OW'(12));
    starve = 1'b0;

    // Back-to-back frames
    do_reset();
    load_frame(1);
    load_frame(101);
    drive_inputs();
    run_to_end(400, "t4");
    check("t4_count", OW'(written), OW'(24));
    check("t4_f2_first", (log_q.size() > 12) ? log_q[12] : '0,
          {1'b1, 8'd106, 8'd105, 8'd0, 8'd102, 8'd101, 8'd0, 8'd0, 8'd0, 8'd0});

    // Reset mid-frame
    do_reset();
    load_frame(1);
    drive_inputs();
    n = 0;
    while (accepted < 7 && n < 100) begin
      cycle();
      n++;
    end
    check("t5_partial", OW'(accepted), OW'(7));
    do_reset();
    load_frame(1);
    drive_inputs();
    run_to_end(200, "t5");
    check("t5_count", OW'(written), OW'(12));
    check("t5_first_win", (log_q.size() > 0) ? log_q[0] : '0,
          {1'b1, 8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
